noc_inst_mem_loader: RTL

//  Upstream stage of the tile instruction memory: consumes program-load packets from the local
//  NoC ejection port, writes the payload words into the 32-bit single-port on-chip RAM via its

---
 rtl/noc_pkg.sv | 25 ++
 rtl/noc_inst_mem_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC instruction-memory loader.
// Holds the header flit field positions, the default program-load type code
// and the loader FSM state encoding.
package noc_pkg;

    // Header flit layout: [31:28] type, [27:16] word count, [15:12] rsvd, [11:0] start address
    localparam int TYPE_HI = 31;
    localparam int TYPE_LO = 28;
    localparam int LEN_HI  = 27;
    localparam int LEN_LO  = 16;
    localparam int RSVD_HI = 15;
    localparam int RSVD_LO = 12;
    localparam int ADDR_HI = 11;
    localparam int ADDR_LO = 0;

    localparam logic [3:0] TYPE_LOAD_DEF = 4'h1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/noc_inst_mem_loader.sv
// Program loader between the NoC ejection port and the tile instruction RAM.
// Parses program-load packets, writes each payload word through the RAM's
// Avalon slave one cycle after the flit is accepted, and holds the tile CPU
// in reset for the duration of a load.
//
// Ports
//   clk, reset                 single clock, async active-high reset
//   flit_valid/data/last       NoC ejection flit stream
//   flit_ready                 always 1; the RAM never stalls
//   mem_*                      Avalon slave of the single-port RAM
//   cpu_reset_req              high while a load is in progress
//   load_done                  1-cycle pulse after a clean load
//   err_count                  saturating malformed-packet counter
//
// state | meaning
// IDLE  | waiting for a header flit
// DATA  | writing payload words, rem_q words still expected
// DRAIN | discarding the rest of a bad/overlong packet
// DONE  | final word is being written this cycle
module noc_inst_mem_loader
    import noc_pkg::*;
#(
    parameter int         ADDR_W    = 12,
    parameter int         DATA_W    = 32,
    parameter logic [3:0] TYPE_LOAD = TYPE_LOAD_DEF,
    parameter bit         HOLD_CPU  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flit_valid,
    input  logic [DATA_W-1:0] flit_data,
    input  logic              flit_last,
    output logic              flit_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    output logic              cpu_reset_req,
    output logic              load_done,
    output logic [7:0]        err_count
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       rem_q, rem_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic [7:0]        err_q, err_d;
    logic              err_inc;

    logic [3:0]  hdr_type;
    logic [11:0] hdr_len;
    logic [11:0] hdr_addr;
    logic        hdr_ok;
    logic        unused_rsvd;

    assign hdr_type    = flit_data[TYPE_HI:TYPE_LO];
    assign hdr_len     = flit_data[LEN_HI:LEN_LO];
    assign hdr_addr    = flit_data[ADDR_HI:ADDR_LO];
    assign hdr_ok      = (hdr_type == TYPE_LOAD) && (hdr_len != 12'd0) && !flit_last;
    assign unused_rsvd = ^flit_data[RSVD_HI:RSVD_LO];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (flit_valid) begin
                    if (hdr_ok) begin
                        state_d = DATA;
                        addr_d  = ADDR_W'(hdr_addr);
                        rem_d   = hdr_len;
                    end else begin
                        err_inc = 1'b1;
                        if (!flit_last) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DATA: begin
                if (flit_valid) begin
                    // Every accepted data flit is written, even on a malformed packet.
                    wr_d      = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = flit_data;
                    addr_d    = addr_q + 1'b1;
                    rem_d     = rem_q - 12'd1;
                    if (rem_q == 12'd1) begin
                        if (flit_last) begin
                            state_d = DONE;
                        end else begin
                            err_inc = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (flit_last) begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (flit_valid && flit_last) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The pending write term keeps the CPU held across the write that
        // trails an early exit from DATA.
        cpu_rst_d = HOLD_CPU && ((state_d == DATA) || (state_d == DONE) || wr_d);
        done_d    = (state_q == DONE);
        err_d     = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign flit_ready     = 1'b1;
    assign mem_address    = wr_addr_q;
    assign mem_byteenable = 4'hF;
    assign mem_chipselect = wr_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = wr_data_q;
    assign mem_clken      = 1'b1;
    assign cpu_reset_req  = cpu_rst_q;
    assign load_done      = done_q;
    assign err_count      = err_q;

endmodule
